// File: rtl/legv8_inst_encoder_loader_if.sv
// Field-level instruction stream in, instruction-memory write port out.
// The slave side is the loader; the master side is whoever feeds programs and models memory.
interface legv8_inst_encoder_loader_if #(
   parameter int ADDR_WIDTH = 6
);
   logic                  start;
   logic [ADDR_WIDTH-1:0] start_addr;
   logic                  in_valid;
   logic                  in_ready;
   logic [2:0]            op_class;
   logic [4:0]            rd;
   logic [4:0]            rn;
   logic [4:0]            rm;
   logic [18:0]           imm;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [31:0]           mem_wdata;
   logic                  mem_ack;
   logic [ADDR_WIDTH:0]   count;
   logic                  full;
   logic                  err;

   modport slave (
      input  start, start_addr, in_valid, op_class, rd, rn, rm, imm, mem_ack,
      output in_ready, mem_we, mem_addr, mem_wdata, count, full, err
   );

   modport master (
      output start, start_addr, in_valid, op_class, rd, rn, rm, imm, mem_ack,
      input  in_ready, mem_we, mem_addr, mem_wdata, count, full, err
   );
endinterface

// File: rtl/legv8_inst_encoder_loader.sv
// Encodes LEGv8 R/D/CB instructions from field descriptions and writes them
// sequentially into instruction memory, one word per accepted request.
module legv8_inst_encoder_loader #(
   parameter int ADDR_WIDTH = 6
) (
   input  logic                          clk,
   input  logic                          rst_n,
   legv8_inst_encoder_loader_if.slave    bus
);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      WRITE = 1'b1
   } state_t;

   localparam logic [ADDR_WIDTH:0]   DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0]   CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [2:0]            OP_ILLEGAL = 3'd7;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
   logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
   logic                  full_q, full_d;
   logic                  err_q, err_d;
   logic [31:0]           wdata_q, wdata_d;

   // Builds the 32-bit word; unused fields (shamt, op2) are forced to zero.
   function automatic logic [31:0] encode(
      input logic [2:0]  op,
      input logic [4:0]  f_rd,
      input logic [4:0]  f_rn,
      input logic [4:0]  f_rm,
      input logic [18:0] f_imm
   );
      logic [31:0] w;
      case (op)
         3'd0:    w = {11'b10001011000, f_rm, 6'b000000, f_rn, f_rd};
         3'd1:    w = {11'b11001011000, f_rm, 6'b000000, f_rn, f_rd};
         3'd2:    w = {11'b10001010000, f_rm, 6'b000000, f_rn, f_rd};
         3'd3:    w = {11'b10101010000, f_rm, 6'b000000, f_rn, f_rd};
         3'd4:    w = {11'b11111000010, f_imm[8:0], 2'b00, f_rn, f_rd};
         3'd5:    w = {11'b11111000000, f_imm[8:0], 2'b00, f_rn, f_rd};
         3'd6:    w = {8'b10110100, f_imm, f_rd};
         default: w = 32'h0000_0000;
      endcase
      return w;
   endfunction

   // State and datapath registers; reset also drops a pending write immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         cnt_q   <= '0;
         full_q  <= 1'b0;
         err_q   <= 1'b0;
         wdata_q <= 32'h0000_0000;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         full_q  <= full_d;
         err_q   <= err_d;
         wdata_q <= wdata_d;
      end
   end

   // Next-state logic: start has priority over a transfer while idle.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      full_d  = full_q;
      err_d   = 1'b0;
      wdata_d = wdata_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               ptr_d  = bus.start_addr;
               cnt_d  = '0;
               full_d = 1'b0;
            end else if (bus.in_valid && !full_q) begin
               if (bus.op_class == OP_ILLEGAL) begin
                  err_d = 1'b1;
               end else begin
                  wdata_d = encode(bus.op_class, bus.rd, bus.rn, bus.rm, bus.imm);
                  state_d = WRITE;
               end
            end else begin
               state_d = IDLE;
            end
         end
         WRITE: begin
            // The pointer wraps silently; full is judged on the count alone.
            if (bus.mem_ack) begin
               state_d = IDLE;
               ptr_d   = ptr_q + PTR_ONE;
               cnt_d   = cnt_q + CNT_ONE;
               full_d  = ((cnt_q + CNT_ONE) == DEPTH_C);
            end else begin
               state_d = WRITE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output mapping; only in_ready depends combinationally on an input.
   always_comb begin
      bus.in_ready  = (state_q == IDLE) && !full_q && !bus.start;
      bus.mem_we    = (state_q == WRITE);
      bus.mem_addr  = ptr_q;
      bus.mem_wdata = wdata_q;
      bus.count     = cnt_q;
      bus.full      = full_q;
      bus.err       = err_q;
   end

endmodule

// File: tb/tb_legv8_inst_encoder_loader.sv
// Self-checking bench: hand-computed vector table, corner-case sequences and
// randomized traffic against an arithmetic encoding / address model.
module tb_legv8_inst_encoder_loader;

   localparam int AW    = 2;
   localparam int DEPTH = 1 << AW;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   int   base;
   int   cnt;

   legv8_inst_encoder_loader_if #(.ADDR_WIDTH(AW)) bus ();

   legv8_inst_encoder_loader #(.ADDR_WIDTH(AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   typedef struct {
      logic [2:0]  op;
      logic [4:0]  rd;
      logic [4:0]  rn;
      logic [4:0]  rm;
      logic [18:0] imm;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[8];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference encoder: opcode value scaled into place plus field values scaled into place.
   function automatic logic [31:0] model_word(input int op, input int rd, input int rn,
                                              input int rm, input int imm);
      longint w;
      case (op)
         0: w = 64'h458 * 2097152 + rm * 65536 + rn * 32 + rd;
         1: w = 64'h658 * 2097152 + rm * 65536 + rn * 32 + rd;
         2: w = 64'h450 * 2097152 + rm * 65536 + rn * 32 + rd;
         3: w = 64'h550 * 2097152 + rm * 65536 + rn * 32 + rd;
         4: w = 64'h7C2 * 2097152 + (imm % 512) * 4096 + rn * 32 + rd;
         5: w = 64'h7C0 * 2097152 + (imm % 512) * 4096 + rn * 32 + rd;
         6: w = 64'hB4 * 16777216 + imm * 32 + rd;
         default: w = 0;
      endcase
      return w[31:0];
   endfunction

   task automatic do_start(input int addr);
      @(negedge clk);
      bus.start      = 1'b1;
      bus.start_addr = AW'(addr);
      bus.in_valid   = 1'b1;
      bus.op_class   = 3'd0;
      #1 chk("ready_blocked_by_start", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
      bus.start    = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      base = addr;
      cnt  = 0;
      chk("start_count", 32'(bus.count), 32'd0);
      chk("start_full", 32'(bus.full), 32'd0);
      chk("start_no_we", 32'(bus.mem_we), 32'd0);
      chk("start_ready", 32'(bus.in_ready), 32'd1);
   endtask

   task automatic xfer(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rn,
                       input logic [4:0] rm, input logic [18:0] imm, input logic [31:0] exp_word,
                       input int delay, input bit noise);
      logic [31:0] exp_addr;
      @(negedge clk);
      bus.op_class = op;
      bus.rd       = rd;
      bus.rn       = rn;
      bus.rm       = rm;
      bus.imm      = imm;
      bus.in_valid = 1'b1;
      #1 chk("ready_before", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      #1;
      if (op == 3'd7) begin
         chk("err_pulse", 32'(bus.err), 32'd1);
         chk("err_no_we", 32'(bus.mem_we), 32'd0);
         chk("err_count", 32'(bus.count), 32'(cnt));
         @(negedge clk);
         #1;
         chk("err_cleared", 32'(bus.err), 32'd0);
         chk("err_ready", 32'(bus.in_ready), 32'd1);
      end else begin
         exp_addr = 32'((base + cnt) % DEPTH);
         chk("we_rise", 32'(bus.mem_we), 32'd1);
         chk("addr", 32'(bus.mem_addr), exp_addr);
         chk("wdata", bus.mem_wdata, exp_word);
         chk("ready_in_write", 32'(bus.in_ready), 32'd0);
         if (noise) begin
            bus.start      = 1'b1;
            bus.start_addr = AW'(base + 1);
            bus.in_valid   = 1'b1;
            bus.op_class   = 3'd1;
         end
         for (int k = 0; k < delay; k++) begin
            @(negedge clk);
            #1;
            chk("hold_we", 32'(bus.mem_we), 32'd1);
            chk("hold_addr", 32'(bus.mem_addr), exp_addr);
            chk("hold_wdata", bus.mem_wdata, exp_word);
            chk("hold_ready", 32'(bus.in_ready), 32'd0);
         end
         bus.mem_ack = 1'b1;
         @(negedge clk);
         bus.mem_ack  = 1'b0;
         bus.start    = 1'b0;
         bus.in_valid = 1'b0;
         #1;
         cnt++;
         chk("ack_we_low", 32'(bus.mem_we), 32'd0);
         chk("ack_count", 32'(bus.count), 32'(cnt));
         chk("ack_full", 32'(bus.full), 32'(cnt == DEPTH));
         chk("ack_ready", 32'(bus.in_ready), 32'(cnt != DEPTH));
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      base   = 0;
      cnt    = 0;
      rst_n          = 1'b0;
      bus.start      = 1'b0;
      bus.start_addr = '0;
      bus.in_valid   = 1'b0;
      bus.op_class   = 3'd0;
      bus.rd         = 5'd0;
      bus.rn         = 5'd0;
      bus.rm         = 5'd0;
      bus.imm        = 19'd0;
      bus.mem_ack    = 1'b0;

      vecs[0] = '{3'd0, 5'd1,  5'd2,  5'd3,  19'h00010, 32'h8B030041};
      vecs[1] = '{3'd4, 5'd5,  5'd6,  5'd0,  19'h00010, 32'hF84100C5};
      vecs[2] = '{3'd5, 5'd5,  5'd6,  5'd0,  19'h001FF, 32'hF81FF0C5};
      vecs[3] = '{3'd1, 5'd31, 5'd31, 5'd31, 19'h00000, 32'hCB1F03FF};
      vecs[4] = '{3'd3, 5'd0,  5'd0,  5'd0,  19'h7FFFF, 32'hAA000000};
      vecs[5] = '{3'd2, 5'd4,  5'd8,  5'd16, 19'h00000, 32'h8A100104};
      vecs[6] = '{3'd4, 5'd0,  5'd1,  5'd7,  19'h7FE01, 32'hF8401020};
      vecs[7] = '{3'd6, 5'd9,  5'd3,  5'd3,  19'h7FFFF, 32'hB4FFFFE9};

      repeat (2) @(negedge clk);
      #1;
      chk("rst_we", 32'(bus.mem_we), 32'd0);
      chk("rst_addr", 32'(bus.mem_addr), 32'd0);
      chk("rst_wdata", bus.mem_wdata, 32'd0);
      chk("rst_count", 32'(bus.count), 32'd0);
      chk("rst_full", 32'(bus.full), 32'd0);
      chk("rst_err", 32'(bus.err), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      #1 chk("rst_ready", 32'(bus.in_ready), 32'd1);

      // Hand-computed vector table; the loader is restarted whenever it fills.
      do_start(0);
      for (int i = 0; i < 8; i++) begin
         if (cnt == DEPTH) do_start(0);
         xfer(vecs[i].op, vecs[i].rd, vecs[i].rn, vecs[i].rm, vecs[i].imm, vecs[i].exp, i % 2, 1'b0);
      end

      // Slow ack with start/in_valid noise during the write.
      do_start(1);
      xfer(3'd6, 5'd9, 5'd0, 5'd0, 19'h7FFFF, 32'hB4FFFFE9, 3, 1'b1);
      chk("noise_ptr_kept", 32'(bus.mem_addr), 32'd2);

      // Illegal op class.
      xfer(3'd7, 5'd1, 5'd1, 5'd1, 19'd0, 32'd0, 0, 1'b0);
      chk("illegal_ptr_kept", 32'(bus.mem_addr), 32'd2);

      // Wrap from address 3, fill, check transfers are blocked until start.
      do_start(3);
      for (int i = 0; i < 4; i++)
         xfer(3'd0, 5'(i), 5'd2, 5'd3, 19'd0, model_word(0, i, 2, 3, 0), 0, 1'b0);
      @(negedge clk);
      bus.in_valid = 1'b1;
      #1 chk("full_ready", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      #1 chk("full_no_we", 32'(bus.mem_we), 32'd0);
      chk("full_held", 32'(bus.full), 32'd1);
      do_start(0);

      // Reset asserted while a write is pending.
      @(negedge clk);
      bus.op_class = 3'd0;
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      #1 chk("pre_rst_we", 32'(bus.mem_we), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("async_rst_we", 32'(bus.mem_we), 32'd0);
      chk("async_rst_count", 32'(bus.count), 32'd0);
      chk("async_rst_addr", 32'(bus.mem_addr), 32'd0);
      chk("async_rst_wdata", bus.mem_wdata, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      bus.mem_ack = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("post_rst_we", 32'(bus.mem_we), 32'd0);
      chk("post_rst_count", 32'(bus.count), 32'd0);
      bus.mem_ack = 1'b0;
      base = 0;
      cnt  = 0;

      // Randomized traffic against the reference model.
      for (int i = 0; i < 40; i++) begin
         int op, rd, rn, rm, imm;
         op  = int'($urandom_range(0, 7));
         rd  = int'($urandom_range(0, 31));
         rn  = int'($urandom_range(0, 31));
         rm  = int'($urandom_range(0, 31));
         imm = int'($urandom_range(0, 19'h7FFFF));
         if (cnt == DEPTH || $urandom_range(0, 5) == 0) do_start(int'($urandom_range(0, DEPTH - 1)));
         xfer(3'(op), 5'(rd), 5'(rn), 5'(rm), 19'(imm), model_word(op, rd, rn, rm, imm),
              int'($urandom_range(0, 3)), $urandom_range(0, 3) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/legv8_inst_encoder_loader.md
Name: legv8_inst_encoder_loader

Overview:
- Writer-side counterpart of the opcode decoder.
- Accepts field-level instruction descriptions over a valid/ready handshake and encodes each into a 32-bit LEGv8 word (R, D or CB format).
- Writes the words sequentially into instruction memory through a write/ack interface.
- Used by the bench/boot path to load programs that the datapath's control decoder later consumes.

Parameters:
- ADDR_WIDTH, 6, word-address width of the instruction memory port; DEPTH = 2^ADDR_WIDTH words.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  load address pointer from start_addr and clear count; effective only in IDLE
- start_addr  input  ADDR_WIDTH  first word address of a load session
- in_valid  input  1  instruction fields valid
- in_ready  output  1  block can accept fields
- op_class  input  3  0 ADD, 1 SUB, 2 AND, 3 ORR, 4 LDUR, 5 STUR, 6 CBZ, 7 illegal
- rd  input  5  Rd (R-format) or Rt (D/CB-format)
- rn  input  5  Rn
- rm  input  5  Rm (R-format only)
- imm  input  19  DT_address in imm[8:0] for D-format; COND_BR_address in imm[18:0] for CBZ
- mem_we  output  1  memory write request
- mem_addr  output  ADDR_WIDTH  write word address
- mem_wdata  output  32  encoded instruction
- mem_ack  input  1  memory accepted the write this cycle
- count  output  ADDR_WIDTH+1  words written since reset/start
- full  output  1  count == DEPTH
- err  output  1  one-cycle pulse: illegal op_class accepted

Behaviour:
- Clock/reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: state IDLE, mem_we 0, mem_addr 0, mem_wdata 0, count 0, full 0, err 0. in_ready is 1 from the first cycle after reset deasserts.
- FSM states: IDLE, WRITE.
- in_ready = (state==IDLE) && !full && !start.
- A handshake occurs when in_valid && in_ready at a rising edge.
- IDLE, start=1: pointer <= start_addr, count <= 0, full <= 0. No transfer in that cycle.
- IDLE, handshake with legal op_class: register the encoded word into mem_wdata and enter WRITE. mem_we is 1 on the next cycle, so latency from handshake to mem_we is 1 cycle.
- IDLE, handshake with op_class 7: err=1 for exactly the next cycle. No write, pointer and count unchanged, stay in IDLE.
- WRITE: mem_we, mem_addr and mem_wdata are held stable until mem_ack=1. On the ack edge: mem_we <= 0, pointer +1 (mod DEPTH, wraps silently), count +1, full <= (count+1 == DEPTH), return to IDLE.
- Throughput: at most one word per 2 cycles. mem_ack in the same cycle mem_we rises completes the write.
- start or in_valid during WRITE is ignored. start held high in IDLE blocks transfers.
- full: in_ready stays 0 until start. Wrap-around with start_addr ≠ 0 is legal; full depends on count only.
- Encoding, shamt/op2 fields = 0:
  - ADD: word[31:21]=10001011000
  - SUB: word[31:21]=11001011000
  - AND: word[31:21]=10001010000
  - ORR: word[31:21]=10101010000
  - R-format layout: [20:16]=rm, [15:10]=0, [9:5]=rn, [4:0]=rd
  - LDUR: word[31:21]=11111000010; STUR: word[31:21]=11111000000
  - D-format layout: [20:12]=imm[8:0], [11:10]=00, [9:5]=rn, [4:0]=rd. imm[18:9] is ignored.
  - CBZ: [31:24]=10110100, [23:5]=imm, [4:0]=rd. rn and rm are ignored.
- rst_n asserted mid-WRITE: mem_we drops immediately (asynchronously) and the pending word is discarded. All state returns to reset values.

Test Plan:
- Reset, start=1 with start_addr=0, then ADD rd=1 rn=2 rm=3 -> mem_we 1 cycle after handshake, mem_addr=0, mem_wdata=0x8B030041. Ack -> count=1.
- LDUR rd=5 rn=6 imm=0x10, then STUR rd=5 rn=6 imm=0x1FF -> words 0xF84100C5 and 0xF81FF0C5 at consecutive addresses. Decoder fed word[31:21] gives MemRead=1 for the first and MemWrite=1 for the second.
- CBZ rd=9 imm=0x7FFFF, ack delayed 3 cycles -> mem_we/addr/wdata stable all 3 cycles, wdata=0xB4FFFFE9, in_ready=0 until the ack edge.
- op_class=7 handshake -> err high exactly one cycle, no mem_we, count unchanged, in_ready back to 1 next cycle.
- ADDR_WIDTH=2, start_addr=3, four writes -> addresses 3,0,1,2. full=1 after the 4th ack, in_ready=0 until start.
- Drop rst_n while mem_we=1 -> mem_we 0 in the same cycle, count=0, mem_addr=0. No write completes after release.
